// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
// Shared helpers for the pipelined adder slice.
//   SEG_W(width, stages)       : bits handled by one pipeline segment.
//   `ADDER_PARAMS_OK(W, S)     : true when WIDTH/STAGES form a legal pairing
//                                (S >= 1, W >= 2, W divisible by S).
// The per-stage register struct (stage_t) depends on WIDTH, so it is declared
// inside pipelined_adder where WIDTH is known; a package cannot be
// parameterised.
// ---------------------------------------------------------------------------
`ifndef ADDER_PKG_SV
`define ADDER_PKG_SV

// The divisor is clamped so the expression stays well defined when S < 1.
`define ADDER_PARAMS_OK(W, S) \
  (((S) >= 1) && ((W) >= 2) && (((W) % (((S) >= 1) ? (S) : 1)) == 0))

package adder_pkg;

  function automatic int SEG_W(input int width, input int stages);
    return (stages >= 1) ? (width / stages) : width;
  endfunction

endpackage

`endif

// File: rtl/adder_segment.sv
// ---------------------------------------------------------------------------
// adder_segment
// Purely combinational W-bit ripple-carry adder built from full-adder cells.
// Ports:
//   a_i, b_i [W-1:0] : operand slices
//   c_i              : carry into bit 0
//   s_o      [W-1:0] : sum slice
//   c_o              : carry out of bit W-1
// ---------------------------------------------------------------------------
module adder_segment #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] s_o,
  output logic         c_o
);

  logic carry;

  always_comb begin
    // NOTE: blocking assignments here are intentional: 'carry' is a procedural
    // temporary that must update bit by bit inside the loop to form the ripple.
    s_o   = '0;
    carry = c_i;
    for (int i = 0; i < W; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry  = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    c_o = carry;
  end

endmodule

// File: rtl/pipelined_adder.sv
// ---------------------------------------------------------------------------
// pipelined_adder
// WIDTH-bit adder with carry-in, carry-out and signed overflow. The carry
// chain is cut into STAGES equal ripple segments with one register stage per
// segment; latency is STAGES accepted-and-advancing cycles. Valid/ready on
// both sides with full backpressure: the whole pipe advances together
// whenever the output slot is empty or being drained.
// Optional feature: define ADDER_SUB_EN to add the 'sub' port
// (effective B = ~b, effective carry-in = cin ^ sub).
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready is combinational)
//   a, b, cin [, sub]    : operands
//   out_valid / out_ready: result handshake
//   sum, cout, ovf       : result, carry out of MSB, signed overflow
// ---------------------------------------------------------------------------
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = SEG_W(WIDTH, STAGES);

  if (!`ADDER_PARAMS_OK(WIDTH, STAGES)) begin : g_param_err
    $error("pipelined_adder: need STAGES >= 1, WIDTH >= 2 and WIDTH %% STAGES == 0");
  end

  // One pipeline stage. Operands travel at full width; stage k only reads
  // segment k of them. sum_done accumulates finished low segments.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] a_rem;
    logic [WIDTH-1:0] b_rem;
    logic [WIDTH-1:0] sum_done;
    logic             a_msb;
    logic             b_msb;
  } stage_t;

  stage_t pipe_q [STAGES];
  stage_t pipe_d [STAGES];

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Subtraction is folded in at the entry: the inverted B and adjusted carry
  // are what travel down the pipe, so 'sub' needs no register of its own.
`ifdef ADDER_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = cin ^ sub;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  // A bubble in the output slot never blocks the pipe.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t         src;
    stage_t         nxt;
    logic [SEG-1:0] seg_s;
    logic           seg_co;

    if (k == 0) begin : g_entry
      always_comb begin
        // NOTE: every field gets a value before selective overrides, so no
        // path leaves a bit unassigned and no latch is inferred.
        src          = '0;
        src.valid    = in_valid;
        src.carry    = cin_eff;
        src.a_rem    = a;
        src.b_rem    = b_eff;
        src.a_msb    = a[WIDTH-1];
        src.b_msb    = b_eff[WIDTH-1];
      end
    end else begin : g_mid
      assign src = pipe_q[k-1];
    end

    adder_segment #(.W(SEG)) u_seg (
      .a_i (src.a_rem[k*SEG +: SEG]),
      .b_i (src.b_rem[k*SEG +: SEG]),
      .c_i (src.carry),
      .s_o (seg_s),
      .c_o (seg_co)
    );

    always_comb begin
      nxt                        = src;
      nxt.carry                  = seg_co;
      nxt.sum_done[k*SEG +: SEG] = seg_s;
    end

    assign pipe_d[k] = nxt;
  end

  // NOTE: datapath fields are reset along with the valid bits because the
  // outputs must read zero straight out of reset, not just be flagged invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) pipe_q[k] <= '0;
    end else if (adv) begin
      // NOTE: non-blocking assignments let every stage capture its
      // predecessor's old value on the same edge.
      for (int k = 0; k < STAGES; k++) pipe_q[k] <= pipe_d[k];
    end
  end

  assign out_valid = pipe_q[STAGES-1].valid;
  assign sum       = pipe_q[STAGES-1].sum_done;
  assign cout      = pipe_q[STAGES-1].carry;
  assign ovf       = (pipe_q[STAGES-1].a_msb == pipe_q[STAGES-1].b_msb) &&
                     (pipe_q[STAGES-1].sum_done[WIDTH-1] != pipe_q[STAGES-1].a_msb);

endmodule

// File: tb/tb_pipelined_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_adder
// Three instances (STAGES = 4, 1, 16; WIDTH = 16) share one stimulus stream.
// Each accepted operand set pushes its expected result (computed with plain
// integer arithmetic) onto that instance's queue; a negedge monitor pops and
// compares whenever an instance hands a result downstream.
// Define ADDER_SUB_EN to exercise the subtract path as well.
// ---------------------------------------------------------------------------
module tb_pipelined_adder;

  localparam int W = 16;
  localparam int N = 3;

`ifdef ADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           acc_cyc;
    bit           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_ready;

  logic         in_rdy [N];
  logic         ov     [N];
  logic [W-1:0] so     [N];
  logic         co     [N];
  logic         of     [N];

  exp_t sb [N][$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   steady   = 1'b0;
  bit   saw_block;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int st_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 1 : 16;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    pipelined_adder #(.WIDTH(W), .STAGES((g == 0) ? 4 : (g == 1) ? 1 : 16)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_rdy[g]),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef ADDER_SUB_EN
      .sub       (sub),
`endif
      .out_valid (ov[g]),
      .out_ready (out_ready),
      .sum       (so[g]),
      .cout      (co[g]),
      .ovf       (of[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: {cout,sum} from unsigned arithmetic, overflow from whether the
  // true signed result leaves the representable range.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic ci, input logic si);
    exp_t        e;
    logic [W-1:0] be;
    logic         s_on;
    int unsigned  ce;
    int unsigned  r;
    int           rs;
    s_on = si & SUB_EN;
    be   = s_on ? ~bv : bv;
    ce   = int'(ci ^ s_on);
    r    = int'(av) + int'(be) + ce;
    rs   = int'($signed(av)) + int'($signed(be)) + int'(ce);
    e.s  = r[W-1:0];
    e.c  = r[W];
    e.o  = (rs > 32767) || (rs < -32768);
    e.acc_cyc = 0;
    e.lat     = 1'b0;
    return e;
  endfunction

  // One cycle of stimulus; records an expectation for every instance that
  // accepts at the upcoming edge. acc reports acceptance by the STAGES=4 one.
  task automatic drive(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ci, input logic si, input logic ro, output bit acc);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid  = v;
    a         = av;
    b         = bv;
    cin       = ci;
    sub       = si;
    out_ready = ro;
    #1;
    acc = v && in_rdy[0] && rst_n;
    if (v && !in_rdy[0]) saw_block = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (v && in_rdy[k] && rst_n) begin
        e         = model(av, bv, ci, si);
        e.acc_cyc = cyc;
        e.lat     = steady;
        sb[k].push_back(e);
      end
    end
  endtask

  task automatic send_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic ci, input logic si, input logic ro);
    bit acc;
    int tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 100) begin
      drive(1'b1, av, bv, ci, si, ro, acc);
      tries++;
    end
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    idle(1);
    while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < 200) begin
      idle(1);
      n++;
    end
    for (int k = 0; k < N; k++) check($sformatf("drain_q%0d", k), 32'(sb[k].size()), 32'd0);
  endtask

  // Monitor: at the negedge the outputs and out_ready are settled, so a
  // transfer at the next edge is exactly ov && out_ready.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      check("in_ready_rule", 32'(in_rdy[0]), 32'(!ov[0] || out_ready));
      for (int k = 0; k < N; k++) begin
        if (ov[k] && out_ready) begin
          if (sb[k].size() == 0) begin
            check($sformatf("unexpected_out_d%0d", k), 32'(ov[k]), 32'd0);
          end else begin
            e = sb[k].pop_front();
            check($sformatf("sum_d%0d", k),  32'(so[k]), 32'(e.s));
            check($sformatf("cout_d%0d", k), 32'(co[k]), 32'(e.c));
            check($sformatf("ovf_d%0d", k),  32'(of[k]), 32'(e.o));
            if (e.lat) check($sformatf("latency_d%0d", k), 32'(cyc - e.acc_cyc), 32'(st_of(k)));
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] ta;
  logic [W-1:0] tb_v;
  logic [W-1:0] corner [4];
  bit           acc_r;

  initial begin
    corner[0] = 16'hFFFF;
    corner[1] = 16'h7FFF;
    corner[2] = 16'h8000;
    corner[3] = 16'h0000;
    rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    for (int k = 0; k < N; k++) begin
      check($sformatf("rst_valid_d%0d", k), 32'(ov[k]), 32'd0);
      check($sformatf("rst_sum_d%0d", k),   32'(so[k]), 32'd0);
      check($sformatf("rst_cout_d%0d", k),  32'(co[k]), 32'd0);
      check($sformatf("rst_ovf_d%0d", k),   32'(of[k]), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases with out_ready held high, latency checked.
    steady = 1'b1;
    send_op(16'h1234, 16'h0FF0, 1'b0, 1'b0, 1'b1);
    send_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    send_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
`ifdef ADDER_SUB_EN
    send_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
    send_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
`endif
    drain();
    steady = 1'b0;

    // Backpressure: 8 back-to-back sets, out_ready low on cycles 3..7.
    saw_block = 1'b0;
    begin
      int c;
      c = 0;
      for (int n = 0; n < 8; n++) begin
        ta    = 16'($urandom);
        tb_v  = 16'($urandom);
        acc_r = 1'b0;
        while (!acc_r && c < 100) begin
          drive(1'b1, ta, tb_v, 1'(n % 2), 1'b0, !(c >= 3 && c <= 7), acc_r);
          c++;
        end
      end
    end
    check("backpressure_block", 32'(saw_block), 32'd1);
    drain();

    // Reset with operations in flight.
    for (int n = 0; n < 6; n++) send_op(16'(n * 16'h1111), 16'h0101, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2 rst_n = 1'b0;
    for (int k = 0; k < N; k++) sb[k].delete();
    #1;
    for (int k = 0; k < N; k++) check($sformatf("midrst_valid_d%0d", k), 32'(ov[k]), 32'd0);
    check("midrst_sum", 32'(so[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(30);
    for (int k = 0; k < N; k++) check($sformatf("post_rst_idle_d%0d", k), 32'(ov[k]), 32'd0);

    // Randomised streaming with random gaps and random downstream stalls.
    for (int i = 0; i < 600; i++) begin
      ta   = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
      tb_v = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
      drive($urandom_range(0, 3) != 0, ta, tb_v, 1'($urandom), 1'($urandom),
            $urandom_range(0, 3) != 0, acc_r);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
